// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: stage/request indices
// and the default 6-stage, 10-request stall/flush mask tables.
package pipe_ctrl_pkg;

  localparam int NSTAGE_DEF = 6;
  localparam int NREQ_DEF   = 10;

  localparam int PC     = 0;
  localparam int PRE_IF = 1;
  localparam int IF_ID  = 2;
  localparam int ID_EX  = 3;
  localparam int EX_MEM = 4;
  localparam int MEM_WB = 5;

  localparam int REQ_LOAD_USE   = 0;
  localparam int REQ_DCACHE     = 1;
  localparam int REQ_ICACHE     = 2;
  localparam int REQ_MUL_BUSY   = 3;
  localparam int REQ_BR_MISPRED = 4;
  localparam int REQ_EXCEPTION  = 5;
  localparam int REQ_CSR        = 6;
  localparam int REQ_FENCE      = 7;
  localparam int REQ_DEBUG      = 8;
  localparam int REQ_IRQ        = 9;

  // Slice k (bits [k*6 +: 6]) is request k; bit 0 of each slice is PC.
  localparam logic [NREQ_DEF*NSTAGE_DEF-1:0] DEF_STALL_MASKS = {
    6'b000000,  // irq
    6'b111111,  // debug
    6'b000111,  // fence
    6'b001111,  // csr
    6'b000000,  // exception
    6'b000000,  // branch mispredict
    6'b001111,  // mul busy
    6'b000011,  // icache miss
    6'b011111,  // dcache miss
    6'b000111   // load-use
  };

  localparam logic [NREQ_DEF*NSTAGE_DEF-1:0] DEF_FLUSH_MASKS = {
    6'b000110,  // irq
    6'b000000,  // debug
    6'b001000,  // fence
    6'b010000,  // csr
    6'b111110,  // exception
    6'b001110,  // branch mispredict
    6'b010000,  // mul busy
    6'b000100,  // icache miss
    6'b100000,  // dcache miss
    6'b001000   // load-use
  };

endpackage

// File: rtl/prio_onehot.sv
// Fixed-priority arbiter: grants the lowest-index asserted request, one-hot.
module prio_onehot #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  // Two's-complement trick isolates the lowest set bit.
  assign gnt = req & (~req + N'(1));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: prioritised stall/flush selection, release-cycle
// masking on request falling edges, saturating win counters and a stall watchdog.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int                        NSTAGE        = 6,
  parameter int                        NREQ          = 10,
  parameter logic [NREQ*NSTAGE-1:0]    STALL_MASKS   = '0,
  parameter logic [NREQ*NSTAGE-1:0]    FLUSH_MASKS   = '0,
  parameter logic [NREQ-1:0]           RELEASE_SEL   = '0,
  parameter logic [NSTAGE-1:0]         RELEASE_STALL = '0,
  parameter int                        WD_LIMIT      = 1024,
  parameter int                        CNT_W         = 32,
  localparam int                       SEL_W         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_i,
  output logic [NSTAGE-1:0] stall_o,
  output logic [NSTAGE-1:0] flush_o,
  output logic [NREQ-1:0]   win_o,
  output logic              rel_o,
  output logic              wd_err_o,
  input  logic [SEL_W-1:0]  cnt_sel_i,
  output logic [CNT_W-1:0]  cnt_o,
  input  logic              cnt_clr_i
);

  localparam int WD_W = $clog2(WD_LIMIT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WD_LIMIT);

  logic [NREQ-1:0]   win;
  logic [NREQ-1:0]   req_q;
  logic              rel;
  logic [NSTAGE-1:0] sel_stall;
  logic [NSTAGE-1:0] sel_flush;
  logic [CNT_W-1:0]  cnt [NREQ];
  logic [WD_W-1:0]   wd_cnt;

  prio_onehot #(.N(NREQ)) u_prio (
    .req (req_i),
    .gnt (win)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) req_q <= '0;
    else     req_q <= req_i;
  end

  // req_q is cleared by reset, so no release can fire on the first cycle out.
  assign rel = |(req_q & ~req_i & RELEASE_SEL);

  always_comb begin
    sel_stall = '0;
    sel_flush = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (win[k]) begin
        sel_stall = sel_stall | STALL_MASKS[k*NSTAGE +: NSTAGE];
        sel_flush = sel_flush | FLUSH_MASKS[k*NSTAGE +: NSTAGE];
      end
    end
  end

  always_comb begin
    stall_o = sel_stall;
    flush_o = sel_flush;
    win_o   = win;
    rel_o   = rel;
    if (rst) begin
      stall_o = '0;
      flush_o = '1;
      win_o   = '0;
      rel_o   = 1'b0;
    end else if (rel) begin
      stall_o = sel_stall & RELEASE_STALL;
      flush_o = '0;
    end
  end

  // Release cycles are not credited to the winner.
  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        cnt[g] <= '0;
      else if (cnt_clr_i)
        cnt[g] <= '0;
      else if (win_o[g] && !rel_o && !(&cnt[g]))
        cnt[g] <= cnt[g] + 1'b1;
    end
  end

  always_comb begin
    cnt_o = '0;
    for (int k = 0; k < NREQ; k++)
      if (cnt_sel_i == SEL_W'(k)) cnt_o = cnt[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt   <= '0;
      wd_err_o <= 1'b0;
    end else if (cnt_clr_i) begin
      wd_cnt   <= '0;
      wd_err_o <= 1'b0;
    end else if (stall_o[0]) begin
      if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
      if (wd_cnt == WD_MAX - 1'b1) wd_err_o <= 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: the driver queues hand-computed
// expectations per cycle, a negedge monitor pops and compares them.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int NS = 6;
  localparam int NR = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req_i = '1;
  logic [NS-1:0] stall_o, flush_o;
  logic [NR-1:0] win_o;
  logic          rel_o, wd_err_o;
  logic [3:0]    cnt_sel_i = '0;
  logic [3:0]    cnt_o;
  logic          cnt_clr_i = 1'b0;

  pipe_hazard_ctrl #(
    .NSTAGE        (NS),
    .NREQ          (NR),
    .STALL_MASKS   (DEF_STALL_MASKS),
    .FLUSH_MASKS   (DEF_FLUSH_MASKS),
    .RELEASE_SEL   (10'b0000000001),
    .RELEASE_STALL (6'b000111),
    .WD_LIMIT      (8),
    .CNT_W         (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .stall_o   (stall_o),
    .flush_o   (flush_o),
    .win_o     (win_o),
    .rel_o     (rel_o),
    .wd_err_o  (wd_err_o),
    .cnt_sel_i (cnt_sel_i),
    .cnt_o     (cnt_o),
    .cnt_clr_i (cnt_clr_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [NR-1:0] win;
    logic [NS-1:0] stall;
    logic [NS-1:0] flush;
    logic          rel;
    logic          wd;
    logic [3:0]    cnt;
    logic [5:0]    chk;  // win, stall, flush, rel, wd, cnt
  } exp_t;

  localparam logic [5:0] C_ALL  = 6'b111111;
  localparam logic [5:0] C_NCNT = 6'b011111;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.chk[0]) begin
        checks++;
        if (win_o !== e.win) begin
          errors++;
          $display("FAIL %s win_o got %b want %b", e.name, win_o, e.win);
        end
      end
      if (e.chk[1]) begin
        checks++;
        if (stall_o !== e.stall) begin
          errors++;
          $display("FAIL %s stall_o got %b want %b", e.name, stall_o, e.stall);
        end
      end
      if (e.chk[2]) begin
        checks++;
        if (flush_o !== e.flush) begin
          errors++;
          $display("FAIL %s flush_o got %b want %b", e.name, flush_o, e.flush);
        end
      end
      if (e.chk[3]) begin
        checks++;
        if (rel_o !== e.rel) begin
          errors++;
          $display("FAIL %s rel_o got %b want %b", e.name, rel_o, e.rel);
        end
      end
      if (e.chk[4]) begin
        checks++;
        if (wd_err_o !== e.wd) begin
          errors++;
          $display("FAIL %s wd_err_o got %b want %b", e.name, wd_err_o, e.wd);
        end
      end
      if (e.chk[5]) begin
        checks++;
        if (cnt_o !== e.cnt) begin
          errors++;
          $display("FAIL %s cnt_o got %0d want %0d", e.name, cnt_o, e.cnt);
        end
      end
    end
  end

  // Inputs change 1 ns after the edge; the expectation covers that cycle.
  task automatic step(input string nm, input logic r, input logic [NR-1:0] rq,
                      input logic [3:0] sel, input logic clr,
                      input logic [NR-1:0] ew, input logic [NS-1:0] es,
                      input logic [NS-1:0] ef, input logic er, input logic ewd,
                      input logic [3:0] ec, input logic [5:0] chk);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; req_i = rq; cnt_sel_i = sel; cnt_clr_i = clr;
    e.name = nm; e.win = ew; e.stall = es; e.flush = ef;
    e.rel = er; e.wd = ewd; e.cnt = ec; e.chk = chk;
    exp_q.push_back(e);
  endtask

  initial begin
    step("reset",     1, 10'h3FF, 0, 0, 10'h000, 6'b000000, 6'b111111, 0, 0, 0, C_ALL);
    step("idle",      0, 10'h000, 0, 0, 10'h000, 6'b000000, 6'b000000, 0, 0, 0, C_ALL);
    step("m0",        0, 10'h005, 0, 0, 10'h001, 6'b000111, 6'b001000, 0, 0, 0, C_ALL);
    step("m0_cnt",    0, 10'h005, 0, 0, 10'h001, 6'b000111, 6'b001000, 0, 0, 1, C_ALL);
    step("rel",       0, 10'h004, 0, 0, 10'h004, 6'b000011, 6'b000000, 1, 0, 2, C_ALL);
    step("post_rel",  0, 10'h004, 2, 0, 10'h004, 6'b000011, 6'b000100, 0, 0, 0, C_ALL);
    step("cnt2",      0, 10'h004, 2, 0, 10'h004, 6'b000011, 6'b000100, 0, 0, 1, C_ALL);
    step("idle2",     0, 10'h000, 2, 0, 10'h000, 6'b000000, 6'b000000, 0, 0, 2, C_ALL);
    step("m0b",       0, 10'h001, 0, 0, 10'h001, 6'b000111, 6'b001000, 0, 0, 2, C_ALL);
    step("rel_nowin", 0, 10'h000, 0, 0, 10'h000, 6'b000000, 6'b000000, 1, 0, 3, C_ALL);
    step("clr",       0, 10'h000, 0, 1, 10'h000, 6'b000000, 6'b000000, 0, 0, 3, C_ALL);
    step("clr_done",  0, 10'h000, 0, 0, 10'h000, 6'b000000, 6'b000000, 0, 0, 0, C_ALL);
    for (int i = 0; i < 20; i++)
      step("sat", 0, 10'h008, 3, 0, 10'h008, 6'b001111, 6'b010000, 0,
           (i >= 8), (i > 15) ? 4'd15 : 4'(i), C_ALL);
    step("sel_oor",   0, 10'h008, 12, 0, 10'h008, 6'b001111, 6'b010000, 0, 1, 0, C_ALL);
    step("clr2",      0, 10'h008, 3, 1, 10'h008, 6'b001111, 6'b010000, 0, 1, 15, C_ALL);
    step("clr2_done", 0, 10'h008, 3, 0, 10'h008, 6'b001111, 6'b010000, 0, 0, 0, C_ALL);
    step("clr2_inc",  0, 10'h008, 3, 0, 10'h008, 6'b001111, 6'b010000, 0, 0, 1, C_ALL);
    step("wd_drop",   0, 10'h000, 0, 0, 10'h000, 6'b000000, 6'b000000, 0, 0, 0, C_ALL);
    for (int i = 0; i < 7; i++)
      step("wd7", 0, 10'h008, 3, 0, 10'h008, 6'b001111, 6'b010000, 0, 0, 0, C_NCNT);
    step("wd7_rel",   0, 10'h000, 3, 0, 10'h000, 6'b000000, 6'b000000, 0, 0, 0, C_NCNT);
    step("wd7_after", 0, 10'h000, 3, 0, 10'h000, 6'b000000, 6'b000000, 0, 0, 0, C_NCNT);
    for (int i = 0; i < 8; i++)
      step("wd8", 0, 10'h008, 3, 0, 10'h008, 6'b001111, 6'b010000, 0, 0, 0, C_NCNT);
    step("wd8_rel",   0, 10'h000, 3, 0, 10'h000, 6'b000000, 6'b000000, 0, 1, 0, C_NCNT);
    step("wd8_stick", 0, 10'h000, 3, 0, 10'h000, 6'b000000, 6'b000000, 0, 1, 0, C_NCNT);
    step("pre_rst0",  0, 10'h3FF, 0, 0, 10'h001, 6'b000111, 6'b001000, 0, 1, 0, C_ALL);
    step("pre_rst1",  0, 10'h3FF, 0, 0, 10'h001, 6'b000111, 6'b001000, 0, 1, 1, C_ALL);
    step("rst_mid",   1, 10'h3FF, 0, 0, 10'h000, 6'b000000, 6'b111111, 0, 0, 0, C_ALL);
    step("rst_hold",  1, 10'h3FF, 0, 0, 10'h000, 6'b000000, 6'b111111, 0, 0, 0, C_ALL);
    step("rst_norel", 0, 10'h000, 0, 0, 10'h000, 6'b000000, 6'b000000, 0, 0, 0, C_ALL);
    step("post_rst",  0, 10'h001, 0, 0, 10'h001, 6'b000111, 6'b001000, 0, 0, 0, C_ALL);

    // Let the monitor drain the scoreboard, bounded in cycles.
    for (int n = 0; n < 4 && exp_q.size() != 0; n++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
